// File: rtl/otter_ooo_pkg.sv
// Shared out-of-order types for the OTTER core: RS tags, opcodes, ALU function codes
// and the reservation-station entry layout.
package otter_ooo_pkg;

    localparam int TAG_W = 4;
    typedef logic [TAG_W-1:0] RS_tag_type;
    localparam RS_tag_type TAG_INVALID = '0;

    typedef enum logic [6:0] {
        OPC_NONE   = 7'b0000000,
        OPC_OP_IMM = 7'b0010011,
        OPC_OP     = 7'b0110011
    } opcode_t;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b1000;
    localparam logic [3:0] ALU_OR  = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0111;
    localparam logic [3:0] ALU_XOR = 4'b0100;

    typedef struct packed {
        logic [3:0]  alu_fun;
        opcode_t     opcode;
        RS_tag_type  rd_tag;
        logic [31:0] v1;
        logic [31:0] v2;
        logic        rdy1;
        logic        rdy2;
        RS_tag_type  q1;
        RS_tag_type  q2;
    } rs_entry_t;

    // An idle CDB carries TAG_INVALID and must never wake an operand.
    function automatic logic cdb_match(input RS_tag_type q, input RS_tag_type cdb);
        return (cdb != TAG_INVALID) && (q == cdb);
    endfunction

endpackage

// File: rtl/rs_oldest_select.sv
// Picks the oldest ready entry: older[j][i]=1 means entry j was issued before entry i.
// Purely combinational, one-hot (or zero) grant.
module rs_oldest_select #(
    parameter int DEPTH = 4
) (
    input  logic [DEPTH-1:0]            ready_mask,
    input  logic [DEPTH-1:0][DEPTH-1:0] older,
    output logic [DEPTH-1:0]            grant
);

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_grant
        logic [DEPTH-1:0] blockers;
        always_comb begin
            blockers = '0;
            for (int j = 0; j < DEPTH; j++) begin
                blockers[j] = ready_mask[j] & older[j][gi];
            end
        end
        assign grant[gi] = ready_mask[gi] & ~(|blockers);
    end

endmodule

// File: rtl/alu_reservation_station.sv
// Reservation station in front of the OTTER ALU: buffers issued ops, snoops the CDB
// for missing operands and presents the oldest ready op to the FU until it is done.
module alu_reservation_station
    import otter_ooo_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        issue_valid,
    output logic        issue_ready,
    input  logic [3:0]  issue_alu_fun,
    input  opcode_t     issue_opcode,
    input  RS_tag_type  issue_rd_tag,
    input  logic [31:0] issue_v1,
    input  logic [31:0] issue_v2,
    input  logic        issue_rdy1,
    input  logic        issue_rdy2,
    input  RS_tag_type  issue_q1,
    input  RS_tag_type  issue_q2,
    input  RS_tag_type  cdb_tag,
    input  logic [31:0] cdb_val,
    output logic [31:0] fu_v1,
    output logic [31:0] fu_v2,
    output logic        fu_v1_valid,
    output logic        fu_v2_valid,
    output logic [3:0]  fu_alu_fun,
    output opcode_t     fu_opcode,
    output RS_tag_type  fu_rd_tag,
    input  logic        fu_done
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                      state_reg;
    rs_entry_t                   entry_reg [DEPTH];
    logic [DEPTH-1:0]            valid_reg, inflight_reg;
    logic [DEPTH-1:0][DEPTH-1:0] older_reg;
    logic [DEPTH-1:0]            free_mask, alloc_oh, ready_mask, grant, load_oh, retire_oh;
    logic                        issue_fire, load_en;
    rs_entry_t                   new_entry, sel_entry;

    logic        fu_valid_reg;
    logic [31:0] fu_v1_reg, fu_v2_reg;
    logic [3:0]  fu_alu_fun_reg;
    opcode_t     fu_opcode_reg;
    RS_tag_type  fu_rd_tag_reg;

    assign free_mask   = ~valid_reg;
    assign alloc_oh    = free_mask & (~free_mask + DEPTH'(1));
    assign issue_ready = |free_mask;
    assign issue_fire  = issue_valid & issue_ready & ~flush;

    // Operands produced on the CDB in the issue cycle are captured directly.
    always_comb begin
        new_entry         = '0;
        new_entry.alu_fun = issue_alu_fun;
        new_entry.opcode  = issue_opcode;
        new_entry.rd_tag  = issue_rd_tag;
        new_entry.q1      = issue_q1;
        new_entry.q2      = issue_q2;
        new_entry.rdy1    = issue_rdy1 | cdb_match(issue_q1, cdb_tag);
        new_entry.rdy2    = issue_rdy2 | cdb_match(issue_q2, cdb_tag);
        new_entry.v1      = issue_rdy1 ? issue_v1 : cdb_val;
        new_entry.v2      = issue_rdy2 ? issue_v2 : cdb_val;
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ready
        assign ready_mask[gi] = valid_reg[gi] & ~inflight_reg[gi]
                              & entry_reg[gi].rdy1 & entry_reg[gi].rdy2;
    end

    rs_oldest_select #(.DEPTH(DEPTH)) u_select (
        .ready_mask (ready_mask),
        .older      (older_reg),
        .grant      (grant)
    );

    assign load_en   = ~flush & (|grant) & ((state_reg == IDLE) | fu_done);
    assign load_oh   = grant & {DEPTH{load_en}};
    assign retire_oh = inflight_reg & {DEPTH{(state_reg == BUSY) & fu_done}};

    always_comb begin
        sel_entry = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (grant[i]) sel_entry = entry_reg[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg    <= '0;
            inflight_reg <= '0;
            older_reg    <= '0;
            for (int i = 0; i < DEPTH; i++) entry_reg[i] <= '0;
        end else if (flush) begin
            valid_reg    <= '0;
            inflight_reg <= '0;
            older_reg    <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (retire_oh[i]) begin
                    valid_reg[i]    <= 1'b0;
                    inflight_reg[i] <= 1'b0;
                end else if (load_oh[i]) begin
                    inflight_reg[i] <= 1'b1;
                end
                if (valid_reg[i] && !entry_reg[i].rdy1 && cdb_match(entry_reg[i].q1, cdb_tag)) begin
                    entry_reg[i].v1   <= cdb_val;
                    entry_reg[i].rdy1 <= 1'b1;
                end
                if (valid_reg[i] && !entry_reg[i].rdy2 && cdb_match(entry_reg[i].q2, cdb_tag)) begin
                    entry_reg[i].v2   <= cdb_val;
                    entry_reg[i].rdy2 <= 1'b1;
                end
                // New entry is younger than every entry currently held.
                if (issue_fire && alloc_oh[i]) begin
                    valid_reg[i]    <= 1'b1;
                    inflight_reg[i] <= 1'b0;
                    entry_reg[i]    <= new_entry;
                    for (int j = 0; j < DEPTH; j++) begin
                        older_reg[i][j] <= 1'b0;
                        older_reg[j][i] <= valid_reg[j];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            fu_valid_reg   <= 1'b0;
            fu_v1_reg      <= '0;
            fu_v2_reg      <= '0;
            fu_alu_fun_reg <= '0;
            fu_opcode_reg  <= OPC_NONE;
            fu_rd_tag_reg  <= TAG_INVALID;
        end else if (flush) begin
            state_reg      <= IDLE;
            fu_valid_reg   <= 1'b0;
            fu_v1_reg      <= '0;
            fu_v2_reg      <= '0;
            fu_alu_fun_reg <= '0;
            fu_opcode_reg  <= OPC_NONE;
            fu_rd_tag_reg  <= TAG_INVALID;
        end else if (load_en) begin
            state_reg      <= BUSY;
            fu_valid_reg   <= 1'b1;
            fu_v1_reg      <= sel_entry.v1;
            fu_v2_reg      <= sel_entry.v2;
            fu_alu_fun_reg <= sel_entry.alu_fun;
            fu_opcode_reg  <= sel_entry.opcode;
            fu_rd_tag_reg  <= sel_entry.rd_tag;
        end else if (state_reg == BUSY && fu_done) begin
            state_reg     <= IDLE;
            fu_valid_reg  <= 1'b0;
            fu_rd_tag_reg <= TAG_INVALID;
        end
    end

    assign fu_v1       = fu_v1_reg;
    assign fu_v2       = fu_v2_reg;
    assign fu_v1_valid = fu_valid_reg;
    assign fu_v2_valid = fu_valid_reg;
    assign fu_alu_fun  = fu_alu_fun_reg;
    assign fu_opcode   = fu_opcode_reg;
    assign fu_rd_tag   = fu_rd_tag_reg;

    a_q1_tagged: assert property (@(posedge clk) disable iff (!rst_n)
        (issue_valid && !issue_rdy1) |-> (issue_q1 != TAG_INVALID));
    a_q2_tagged: assert property (@(posedge clk) disable iff (!rst_n)
        (issue_valid && !issue_rdy2) |-> (issue_q2 != TAG_INVALID));
    a_done_busy: assert property (@(posedge clk) disable iff (!rst_n)
        fu_done |-> (state_reg == BUSY));

endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed bench for alu_reservation_station: expected dispatches go into a queue,
// a negedge monitor pops and compares each op the station presents to the FU.
module tb_alu_reservation_station;
    import otter_ooo_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        issue_valid = 1'b0;
    logic        issue_ready;
    logic [3:0]  issue_alu_fun = '0;
    opcode_t     issue_opcode = OPC_OP;
    RS_tag_type  issue_rd_tag = '0;
    logic [31:0] issue_v1 = '0, issue_v2 = '0;
    logic        issue_rdy1 = 1'b1, issue_rdy2 = 1'b1;
    RS_tag_type  issue_q1 = '0, issue_q2 = '0;
    RS_tag_type  cdb_tag = '0;
    logic [31:0] cdb_val = '0;
    logic [31:0] fu_v1, fu_v2;
    logic        fu_v1_valid, fu_v2_valid;
    logic [3:0]  fu_alu_fun;
    opcode_t     fu_opcode;
    RS_tag_type  fu_rd_tag;
    logic        fu_done = 1'b0;

    typedef struct {
        logic [31:0] v1;
        logic [31:0] v2;
        logic [3:0]  fun;
        opcode_t     opc;
        RS_tag_type  tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic prev_valid = 1'b0;
    logic prev_done  = 1'b0;

    always #5 clk = ~clk;

    alu_reservation_station #(.DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_alu_fun(issue_alu_fun), .issue_opcode(issue_opcode), .issue_rd_tag(issue_rd_tag),
        .issue_v1(issue_v1), .issue_v2(issue_v2),
        .issue_rdy1(issue_rdy1), .issue_rdy2(issue_rdy2),
        .issue_q1(issue_q1), .issue_q2(issue_q2),
        .cdb_tag(cdb_tag), .cdb_val(cdb_val),
        .fu_v1(fu_v1), .fu_v2(fu_v2),
        .fu_v1_valid(fu_v1_valid), .fu_v2_valid(fu_v2_valid),
        .fu_alu_fun(fu_alu_fun), .fu_opcode(fu_opcode), .fu_rd_tag(fu_rd_tag),
        .fu_done(fu_done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_op(input logic [31:0] v1, input logic [31:0] v2, input logic [3:0] fun,
                             input opcode_t opc, input RS_tag_type tag);
        exp_t e;
        e.v1 = v1; e.v2 = v2; e.fun = fun; e.opc = opc; e.tag = tag;
        exp_q.push_back(e);
    endtask

    task automatic do_issue(input RS_tag_type tag, input logic [3:0] fun, input opcode_t opc,
                            input logic r1, input logic [31:0] a1, input RS_tag_type q1,
                            input logic r2, input logic [31:0] a2, input RS_tag_type q2);
        issue_valid = 1'b1; issue_rd_tag = tag; issue_alu_fun = fun; issue_opcode = opc;
        issue_rdy1 = r1; issue_v1 = a1; issue_q1 = q1;
        issue_rdy2 = r2; issue_v2 = a2; issue_q2 = q2;
        tick();
        issue_valid = 1'b0; issue_rdy1 = 1'b1; issue_rdy2 = 1'b1;
        issue_q1 = '0; issue_q2 = '0;
    endtask

    task automatic broadcast(input RS_tag_type tag, input logic [31:0] val);
        cdb_tag = tag; cdb_val = val;
        tick();
        cdb_tag = '0; cdb_val = '0;
    endtask

    task automatic finish_op();
        fu_done = 1'b1;
        tick();
        fu_done = 1'b0;
    endtask

    // Monitor: a new presentation is a valid cycle not preceded by the same op.
    always @(negedge clk) begin
        if (rst_n && fu_v1_valid && fu_v2_valid && (!prev_valid || prev_done)) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("[TB] FAIL unexpected_dispatch: got tag %0d, expected no dispatch", fu_rd_tag);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("fu_v1", fu_v1, e.v1);
                check("fu_v2", fu_v2, e.v2);
                check("fu_alu_fun", 32'(fu_alu_fun), 32'(e.fun));
                check("fu_opcode", 32'(fu_opcode), 32'(e.opc));
                check("fu_rd_tag", 32'(fu_rd_tag), 32'(e.tag));
                $display("[TB] dispatch tag=%0d v1=0x%0h v2=0x%0h", fu_rd_tag, fu_v1, fu_v2);
            end
        end
        prev_valid = fu_v1_valid && fu_v2_valid;
        prev_done  = fu_done;
    end

    initial begin
        #3;
        check("reset_valid", 32'(fu_v1_valid | fu_v2_valid), 0);
        check("reset_tag", 32'(fu_rd_tag), 32'(TAG_INVALID));
        check("reset_ready", 32'(issue_ready), 1);
        check("reset_v1", fu_v1, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Both operands ready: presented two cycles after the issue cycle.
        expect_op(32'd5, 32'd7, ALU_ADD, OPC_OP, 4'd3);
        do_issue(4'd3, ALU_ADD, OPC_OP, 1'b1, 32'd5, 4'd0, 1'b1, 32'd7, 4'd0);
        check("lat_not_yet", 32'(fu_v1_valid), 0);
        tick();
        check("lat_valid", 32'(fu_v1_valid & fu_v2_valid), 1);
        finish_op();
        check("done_valid_drop", 32'(fu_v1_valid), 0);
        check("done_tag_invalid", 32'(fu_rd_tag), 32'(TAG_INVALID));
        check("done_ready", 32'(issue_ready), 1);

        // Pending operand waits for the CDB.
        do_issue(4'd4, ALU_SUB, OPC_OP, 1'b0, 32'd0, 4'd2, 1'b1, 32'd3, 4'd0);
        tick(); tick();
        check("pending_no_dispatch", 32'(fu_v1_valid), 0);
        expect_op(32'h10, 32'd3, ALU_SUB, OPC_OP, 4'd4);
        broadcast(4'd2, 32'h10);
        check("snoop_not_same_cycle", 32'(fu_v1_valid), 0);
        tick();
        check("snoop_dispatch", 32'(fu_v1_valid), 1);
        finish_op();

        // Issue-time bypass of a same-cycle broadcast.
        expect_op(32'd1, 32'd9, ALU_OR, OPC_OP_IMM, 4'd5);
        cdb_tag = 4'd6; cdb_val = 32'd9;
        do_issue(4'd5, ALU_OR, OPC_OP_IMM, 1'b1, 32'd1, 4'd0, 1'b0, 32'd0, 4'd6);
        cdb_tag = '0; cdb_val = '0;
        tick();
        check("bypass_dispatch", 32'(fu_v2_valid), 1);
        finish_op();

        // Fill the station, a 5th issue is dropped, slots return after fu_done.
        for (int i = 1; i <= 4; i++) begin
            check("fill_ready", 32'(issue_ready), 1);
            do_issue(RS_tag_type'(i), ALU_AND, OPC_OP, 1'b0, 32'd0, 4'd8, 1'b1, 32'(i), 4'd0);
        end
        check("full_not_ready", 32'(issue_ready), 0);
        do_issue(4'd9, ALU_XOR, OPC_OP, 1'b1, 32'hAA, 4'd0, 1'b1, 32'hBB, 4'd0);
        check("full_still_not_ready", 32'(issue_ready), 0);
        tick();
        check("full_ignored", 32'(fu_v1_valid), 0);
        for (int i = 1; i <= 4; i++) expect_op(32'h20, 32'(i), ALU_AND, OPC_OP, RS_tag_type'(i));
        broadcast(4'd8, 32'h20);
        tick();
        check("full_busy_ready", 32'(issue_ready), 0);
        finish_op();
        check("freed_ready", 32'(issue_ready), 1);
        check("b2b_fill_1", 32'(fu_v1_valid), 1);
        finish_op();
        check("b2b_fill_2", 32'(fu_v1_valid), 1);
        finish_op();
        check("b2b_fill_3", 32'(fu_v1_valid), 1);
        finish_op();
        check("fill_drain_idle", 32'(fu_v1_valid), 0);

        // Younger op readied first goes first; older follows back-to-back.
        do_issue(4'd10, ALU_ADD, OPC_OP, 1'b0, 32'd0, 4'd11, 1'b1, 32'd2, 4'd0);
        do_issue(4'd12, ALU_SUB, OPC_OP, 1'b0, 32'd0, 4'd13, 1'b1, 32'd4, 4'd0);
        expect_op(32'h33, 32'd4, ALU_SUB, OPC_OP, 4'd12);
        broadcast(4'd13, 32'h33);
        tick();
        check("order_b_first", 32'(fu_rd_tag), 32'd12);
        expect_op(32'h44, 32'd2, ALU_ADD, OPC_OP, 4'd10);
        broadcast(4'd11, 32'h44);
        finish_op();
        check("order_b2b_valid", 32'(fu_v1_valid), 1);
        check("order_b2b_tag", 32'(fu_rd_tag), 32'd10);
        finish_op();
        check("order_idle", 32'(fu_v1_valid), 0);

        // Asynchronous reset while busy with three entries held.
        expect_op(32'd1, 32'd2, ALU_ADD, OPC_OP, 4'd1);
        do_issue(4'd1, ALU_ADD, OPC_OP, 1'b1, 32'd1, 4'd0, 1'b1, 32'd2, 4'd0);
        do_issue(4'd2, ALU_ADD, OPC_OP, 1'b0, 32'd0, 4'd14, 1'b1, 32'd0, 4'd0);
        do_issue(4'd3, ALU_ADD, OPC_OP, 1'b0, 32'd0, 4'd14, 1'b1, 32'd0, 4'd0);
        check("pre_reset_busy", 32'(fu_v1_valid), 1);
        rst_n = 1'b0;
        #1;
        check("async_reset_valid", 32'(fu_v1_valid | fu_v2_valid), 0);
        check("async_reset_tag", 32'(fu_rd_tag), 32'(TAG_INVALID));
        tick();
        rst_n = 1'b1;
        tick();
        check("post_reset_ready", 32'(issue_ready), 1);
        broadcast(4'd14, 32'd5);
        tick(); tick();
        check("post_reset_no_stale", 32'(fu_v1_valid), 0);

        // Synchronous flush while busy and full.
        expect_op(32'd6, 32'd7, ALU_XOR, OPC_OP, 4'd1);
        do_issue(4'd1, ALU_XOR, OPC_OP, 1'b1, 32'd6, 4'd0, 1'b1, 32'd7, 4'd0);
        for (int i = 2; i <= 4; i++)
            do_issue(RS_tag_type'(i), ALU_ADD, OPC_OP, 1'b0, 32'd0, 4'd15, 1'b1, 32'd0, 4'd0);
        check("pre_flush_full", 32'(issue_ready), 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_valid", 32'(fu_v1_valid), 0);
        check("flush_tag", 32'(fu_rd_tag), 32'(TAG_INVALID));
        check("flush_ready", 32'(issue_ready), 1);
        broadcast(4'd15, 32'd1);
        tick(); tick();
        check("flush_no_stale", 32'(fu_v1_valid), 0);

        check("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
